boid_xcel_ctrl: RTL and testbench

Sequencing controller for the boid accelerator datapath (`xcel_dp`). It owns the per-frame update loop:
- for each boid i it loads the boid into the datapath's own-state registers;
- streams every other boid through the accumulation pipeline;
- writes the updated x/y/vx/vy back to memory.

Boid state is ping-pong double-buffered in M10K: all reads in a frame come from the source bank, all writes go to the destination bank, and the banks swap at frame end. This keeps neighbour reads consistent within a frame.

---
 rtl/boid_xcel_ctrl.sv | 119 +++++++++++
 tb/tb_boid_xcel_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boid_xcel_ctrl.sv
// Per-frame sequencer for the boid datapath: load own boid, scan all others, write back, swap ping-pong banks.
// Frame = N_BOIDS*(N_BOIDS+4)+1 cycles after start accept; start is sampled only in IDLE, never queued.
module boid_xcel_ctrl #(
  parameter int N_BOIDS = 32,
  parameter int ADDR_W  = $clog2(N_BOIDS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [ADDR_W:0] rd_addr,
  output logic            wr_en,
  output logic [ADDR_W:0] wr_addr,
  output logic            r_en_tot,
  output logic            r_en_itr,
  output logic            acc_clr,
  output logic            bank
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LATCH, S_SCAN, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_BOIDS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic              itr_pend_q, itr_pend_d;
  logic              bank_q, bank_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      itr_pend_q <= 1'b0;
      bank_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      itr_pend_q <= itr_pend_d;
      bank_q     <= bank_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    itr_pend_d = itr_pend_q;
    bank_d     = bank_q;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    rd_addr    = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    r_en_tot   = 1'b0;
    r_en_itr   = 1'b0;
    acc_clr    = 1'b0;
    bank       = bank_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          i_d     = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        rd_addr = {bank_q, i_q};
        acc_clr = 1'b1;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        r_en_tot   = 1'b1;
        j_d        = '0;
        itr_pend_d = 1'b0;
        state_d    = S_SCAN;
      end
      S_SCAN: begin
        // Strobe lags the read address by one cycle to match memory read latency.
        rd_addr    = {bank_q, j_q};
        r_en_itr   = itr_pend_q;
        itr_pend_d = (j_q != i_q);
        if (j_q == LAST_IDX) begin
          j_d     = '0;
          state_d = S_DRAIN;
        end else begin
          j_d = j_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        r_en_itr   = itr_pend_q;
        itr_pend_d = 1'b0;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = {~bank_q, i_q};
        if (i_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + ADDR_W'(1);
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        bank_d  = ~bank_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_boid_xcel_ctrl.sv
// Checks two controller instances (N_BOIDS=4 and 32) cycle by cycle against a closed-form frame model.
module tb_boid_xcel_ctrl;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       wr_en;
    logic       r_en_tot;
    logic       r_en_itr;
    logic       acc_clr;
    logic       bank;
    logic [5:0] rd_addr;
    logic [5:0] wr_addr;
  } ob_t;

  logic clk;
  logic rst_v   [2];
  logic start_v [2];

  logic       busy_a, done_a, wr_en_a, r_en_tot_a, r_en_itr_a, acc_clr_a, bank_a;
  logic [2:0] rd_addr_a, wr_addr_a;
  logic       busy_b, done_b, wr_en_b, r_en_tot_b, r_en_itr_b, acc_clr_b, bank_b;
  logic [5:0] rd_addr_b, wr_addr_b;

  boid_xcel_ctrl #(.N_BOIDS(4), .ADDR_W(2)) u_a (
    .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .busy(busy_a), .done(done_a),
    .rd_addr(rd_addr_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .r_en_tot(r_en_tot_a),
    .r_en_itr(r_en_itr_a), .acc_clr(acc_clr_a), .bank(bank_a)
  );

  boid_xcel_ctrl #(.N_BOIDS(32), .ADDR_W(5)) u_b (
    .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .busy(busy_b), .done(done_b),
    .rd_addr(rd_addr_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .r_en_tot(r_en_tot_b),
    .r_en_itr(r_en_itr_b), .acc_clr(acc_clr_b), .bank(bank_b)
  );

  ob_t obs_a, obs_b;
  assign obs_a = {busy_a, done_a, wr_en_a, r_en_tot_a, r_en_itr_a, acc_clr_a, bank_a,
                  3'b000, rd_addr_a, 3'b000, wr_addr_a};
  assign obs_b = {busy_b, done_b, wr_en_b, r_en_tot_b, r_en_itr_b, acc_clr_b, bank_b,
                  rd_addr_b, wr_addr_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int n_arr  [2] = '{4, 32};
  int aw_arr [2] = '{2, 5};

  bit   m_in [2];
  int   m_k [2];
  bit   m_bank [2];
  int   acc_cyc [2], done_cyc [2], load_cyc [2];
  int   n_done [2], n_wr [2], cnt_itr [2], bidx [2];
  logic [5:0] prev_rd [2];
  bit   prev_acc [2];
  int   wrq[$];
  int   itrq[$];

  function automatic ob_t get_obs(input int x);
    return (x == 0) ? obs_a : obs_b;
  endfunction

  function automatic int flen(input int n);
    return n * (n + 4) + 1;
  endfunction

  // Expected outputs at frame cycle k (1 = first LOAD) derived from the per-boid slot layout.
  function automatic ob_t model(input int n, input int aw, input bit in_f, input int k, input bit bk);
    ob_t o;
    int b, p, j;
    o = '0;
    o.bank = bk;
    if (!in_f) return o;
    o.busy = 1'b1;
    if (k == flen(n)) begin
      o.done = 1'b1;
      return o;
    end
    b = (k - 1) / (n + 4);
    p = (k - 1) % (n + 4);
    if (p == 0) begin
      o.acc_clr = 1'b1;
      o.rd_addr = 6'((int'(bk) << aw) | b);
    end else if (p == 1) begin
      o.r_en_tot = 1'b1;
    end else if (p <= n + 1) begin
      j = p - 2;
      o.rd_addr  = 6'((int'(bk) << aw) | j);
      o.r_en_itr = (j >= 1) && (j - 1 != b);
    end else if (p == n + 2) begin
      o.r_en_itr = (n - 1 != b);
    end else begin
      o.wr_en   = 1'b1;
      o.wr_addr = 6'((int'(!bk) << aw) | b);
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic monitor(input int x, input ob_t o);
    int a, pidx;
    logic [2:0] got3;
    a    = aw_arr[x];
    pidx = int'(prev_rd[x]) & ((1 << a) - 1);
    if (o.r_en_itr) begin
      cnt_itr[x]++;
      got3 = {prev_rd[x][a], (pidx != bidx[x]), prev_acc[x]};
      chk("itr_after_rd", 64'(got3), 64'({o.bank, 1'b1, 1'b0}));
    end
    if (o.r_en_tot) begin
      chk("tot_after_load", 64'({prev_acc[x], prev_rd[x]}),
          64'({1'b1, 6'((int'(o.bank) << a) | bidx[x])}));
    end
    if (o.acc_clr) begin
      cnt_itr[x]  = 0;
      load_cyc[x] = cyc;
    end
    if (o.wr_en) begin
      n_wr[x]++;
      bidx[x]++;
      if (x == 0) begin
        wrq.push_back(int'(o.wr_addr));
        itrq.push_back(cnt_itr[x]);
      end
    end
    if (o.done) begin
      done_cyc[x] = cyc;
      n_done[x]++;
      bidx[x] = 0;
    end
    prev_rd[x]  = o.rd_addr;
    prev_acc[x] = o.acc_clr;
  endtask

  task automatic step();
    ob_t o, e;
    string nm;
    @(posedge clk);
    cyc++;
    for (int x = 0; x < 2; x++) begin
      if (!rst_v[x]) begin
        m_in[x] = 1'b0; m_bank[x] = 1'b0; bidx[x] = 0;
      end else if (!m_in[x]) begin
        if (start_v[x]) begin
          m_in[x] = 1'b1; m_k[x] = 1; acc_cyc[x] = cyc - 1;
        end
      end else if (m_k[x] == flen(n_arr[x])) begin
        m_in[x] = 1'b0; m_bank[x] = ~m_bank[x];
      end else begin
        m_k[x]++;
      end
    end
    @(negedge clk);
    for (int x = 0; x < 2; x++) begin
      o  = get_obs(x);
      e  = model(n_arr[x], aw_arr[x], m_in[x], m_k[x], m_bank[x]);
      nm = (x == 0) ? "cyc_n4" : "cyc_n32";
      chk(nm, 64'(o), 64'(e));
      monitor(x, o);
    end
  endtask

  task automatic run_until_done(input int x, input int budget);
    int nd;
    nd = n_done[x];
    for (int c = 0; c < budget && n_done[x] == nd; c++) step();
    chk((x == 0) ? "done_seen_n4" : "done_seen_n32", 64'(n_done[x] - nd), 64'(1));
  endtask

  task automatic pulse_reset(input int x);
    rst_v[x] = 1'b0;
    step();
    step();
    rst_v[x] = 1'b1;
    step();
  endtask

  initial begin
    ob_t e;
    int nd, nw, rk, k;
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    start_v[0] = 1'b0; start_v[1] = 1'b0;

    e = '0; e.busy = 1'b1; e.acc_clr = 1'b1;
    chk("model_load0", 64'(model(4, 2, 1'b1, 1, 1'b0)), 64'(e));
    e = '0; e.busy = 1'b1; e.wr_en = 1'b1; e.wr_addr = 6'd4;
    chk("model_wr0", 64'(model(4, 2, 1'b1, 8, 1'b0)), 64'(e));
    e = '0; e.busy = 1'b1; e.r_en_itr = 1'b1; e.rd_addr = 6'd1;
    chk("model_itr", 64'(model(4, 2, 1'b1, 12, 1'b0)), 64'(e));
    e = '0; e.busy = 1'b1; e.rd_addr = 6'd2;
    chk("model_self", 64'(model(4, 2, 1'b1, 13, 1'b0)), 64'(e));
    e = '0; e.busy = 1'b1; e.r_en_itr = 1'b1; e.rd_addr = 6'd7; e.bank = 1'b1;
    chk("model_bank1", 64'(model(4, 2, 1'b1, 30, 1'b1)), 64'(e));
    e = '0; e.busy = 1'b1; e.done = 1'b1;
    chk("model_done", 64'(model(4, 2, 1'b1, 33, 1'b0)), 64'(e));

    step();
    step();
    chk("reset_n4", 64'(obs_a), 64'(0));
    chk("reset_n32", 64'(obs_b), 64'(0));
    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    step();

    // Single frame, N=4.
    repeat ($urandom_range(1, 4)) step();
    wrq.delete(); itrq.delete();
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    chk("busy_rise", 64'(obs_a.busy), 64'(1));
    run_until_done(0, 60);
    chk("done_ofs_n4", 64'(done_cyc[0] - acc_cyc[0]), 64'(33));
    chk("wr_count_n4", 64'(wrq.size()), 64'(4));
    for (int q = 0; q < wrq.size() && q < 4; q++) begin
      chk("wr_addr_n4", 64'(wrq[q]), 64'(4 + q));
      chk("itr_per_boid", 64'(itrq[q]), 64'(3));
    end
    step();
    chk("bank_after_n4", 64'(obs_a.bank), 64'(1));

    // Back-to-back frames with start held, N=4.
    pulse_reset(0);
    start_v[0] = 1'b1;
    run_until_done(0, 60);
    for (int c = 0; c < 6 && !obs_a.acc_clr; c++) step();
    start_v[0] = 1'b0;
    chk("idle_gap", 64'(load_cyc[0] - done_cyc[0]), 64'(2));
    chk("f2_rd_bank", 64'(obs_a.rd_addr[2]), 64'(1));
    wrq.delete(); itrq.delete();
    run_until_done(0, 60);
    chk("f2_wr_count", 64'(wrq.size()), 64'(4));
    for (int q = 0; q < wrq.size() && q < 4; q++) chk("f2_wr_addr", 64'(wrq[q]), 64'(q));

    // Start pulses during busy are ignored, N=32.
    rk = int'($urandom_range(10, 1100));
    nd = n_done[1];
    nw = n_wr[1];
    start_v[1] = 1'b1;
    step();
    start_v[1] = 1'b0;
    k = 1;
    while (n_done[1] == nd && k < 1300) begin
      start_v[1] = (k + 1 == 5) || (k + 1 == 500) || (k + 1 == rk);
      step();
      k++;
    end
    start_v[1] = 1'b0;
    chk("done_ofs_n32", 64'(done_cyc[1] - acc_cyc[1]), 64'(1153));
    repeat (10) step();
    chk("one_done_n32", 64'(n_done[1] - nd), 64'(1));
    chk("wr_count_n32", 64'(n_wr[1] - nw), 64'(32));
    chk("idle_after_n32", 64'(obs_b.busy), 64'(0));

    // Asynchronous reset mid-frame, N=32.
    pulse_reset(1);
    start_v[1] = 1'b1;
    step();
    start_v[1] = 1'b0;
    repeat (299) step();
    #2 rst_v[1] = 1'b0;
    #1 chk("async_rst_outs", 64'(obs_b), 64'(0));
    step();
    step();
    rst_v[1] = 1'b1;
    step();
    chk("bank_kept_0", 64'(obs_b.bank), 64'(0));
    nw = n_wr[1];
    repeat ($urandom_range(0, 3)) step();
    start_v[1] = 1'b1;
    step();
    start_v[1] = 1'b0;
    run_until_done(1, 1300);
    chk("done_ofs_rerun", 64'(done_cyc[1] - acc_cyc[1]), 64'(1153));
    chk("wr_count_rerun", 64'(n_wr[1] - nw), 64'(32));
    step();
    chk("bank_after_rerun", 64'(obs_b.bank), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
